// File: rtl/uart_pkg.sv
// Timing constants and state encoding shared by the UART receive and transmit paths.
// Both ends import this package so that baud timing and byte order always agree.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT = 868;
  localparam int unsigned HALF_BIT     = 434;
  localparam int unsigned NUM_BYTES    = 16;
  localparam int unsigned TIMEOUT      = 86800;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } rx_state_t;

  // Counter width that holds every value up to and including the larger limit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial line, acknowledge handshake and assembled-word outputs of the 16-byte receiver.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic                     RX;
  logic                     ACKNOWLEDGE;
  logic [8*NUM_BYTES-1:0]   DATA;
  logic                     RECEIVED;
  logic                     ERROR;

  modport master (
    output RX,
    output ACKNOWLEDGE,
    input  DATA,
    input  RECEIVED,
    input  ERROR
  );

  modport slave (
    input  RX,
    input  ACKNOWLEDGE,
    output DATA,
    output RECEIVED,
    output ERROR
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line plus falling-edge (start-bit) detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic start_edge
);

  logic meta;
  logic sync;
  logic prev;

  // Flops reset to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s       = sync;
  assign start_edge = prev & ~sync;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 LSB-first UART receiver that assembles NUM_BYTES bytes into one word and holds it
// with RECEIVED until acknowledged; a bad stop bit latches ERROR until reset.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned HALF_BIT     = uart_pkg::HALF_BIT,
  parameter int unsigned TIMEOUT      = uart_pkg::TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_frame_if.slave bus
);
  import uart_pkg::*;

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT, TIMEOUT);
  localparam int unsigned BW = $clog2(NUM_BYTES);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

  rx_state_t              state;
  rx_state_t              state_next;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          byte_cnt;
  logic [2:0]             bit_cnt;
  logic [8*NUM_BYTES-1:0] data_q;
  logic                   rx_s;
  logic                   start_edge;
  logic                   tick_half;
  logic                   tick_bit;
  logic                   received;
  logic                   error;

  uart_rx_sync u_sync (
    .clk        (CLK),
    .rst        (RST),
    .rx         (bus.RX),
    .rx_s       (rx_s),
    .start_edge (start_edge)
  );

  assign tick_half = (clk_cnt == HALF_LAST);
  assign tick_bit  = (clk_cnt == BIT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (tick_half) begin
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_bit && (bit_cnt == 3'd7)) begin
          state_next = S_STOP;
        end
      end
      // Leaving at mid stop bit keeps IDLE ready for a back-to-back start edge.
      S_STOP: begin
        if (tick_bit) begin
          if (!rx_s) begin
            state_next = S_ERR;
          end else if (byte_cnt == BYTE_LAST) begin
            state_next = S_DONE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (bus.ACKNOWLEDGE) begin
          state_next = S_IDLE;
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  always_comb begin
    received = 1'b0;
    error    = 1'b0;
    case (state)
      S_DONE:  received = 1'b1;
      S_ERR:   error    = 1'b1;
      default: ;
    endcase
  end

  assign bus.RECEIVED = received;
  assign bus.ERROR    = error;
  assign bus.DATA     = data_q;

  // clk_cnt doubles as the bit timer and, in IDLE with a partial word, the inter-byte timeout.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_cnt  <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            clk_cnt <= '0;
          end else if (byte_cnt != '0) begin
            if (clk_cnt == TO_LAST) begin
              clk_cnt  <= '0;
              byte_cnt <= '0;
            end else begin
              clk_cnt <= clk_cnt + CW'(1);
            end
          end else begin
            clk_cnt <= '0;
          end
        end
        S_START: begin
          if (tick_half) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tick_bit) begin
            clk_cnt                   <= '0;
            data_q[{byte_cnt, bit_cnt}] <= rx_s;
            bit_cnt                   <= bit_cnt + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tick_bit) begin
            clk_cnt <= '0;
            if (rx_s) begin
              byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with scaled bit timing (32 clocks per bit).
module tb_uart_rx_frame;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned TB_CPB  = 32;
  localparam int unsigned TB_HALF = 16;
  localparam int unsigned TB_TO   = 3200;
  localparam realtime BIT_NOM  = 320.0;
  localparam realtime BIT_FAST = 310.4;
  localparam realtime BIT_SLOW = 329.6;

  logic CLK = 1'b0;
  logic RST;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rises = 0;
  int unsigned high_cycles = 0;
  logic        rcv_prev = 1'b0;
  int unsigned r0;
  int unsigned h0;

  uart_rx_frame_if bus ();

  uart_rx_frame #(
    .CLKS_PER_BIT (TB_CPB),
    .HALF_BIT     (TB_HALF),
    .TIMEOUT      (TB_TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.RECEIVED === 1'b1 && rcv_prev !== 1'b1) rises++;
    if (bus.RECEIVED === 1'b1) high_cycles++;
    rcv_prev = bus.RECEIVED;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input realtime bit_t, input logic stop_v);
    bus.RX = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      #(bit_t);
    end
    bus.RX = stop_v;
    #(bit_t);
  endtask

  task automatic send_bytes(input logic [127:0] w, input int n, input realtime bit_t);
    for (int k = 0; k < n; k++) begin
      send_byte(w[8*k +: 8], bit_t, 1'b1);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = b;
    return r;
  endfunction

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = base + 8'(k);
    return r;
  endfunction

  task automatic ack_word(input string tag);
    @(negedge CLK);
    bus.ACKNOWLEDGE = 1'b1;
    @(negedge CLK);
    bus.ACKNOWLEDGE = 1'b0;
    check(tag, 128'(bus.RECEIVED), 128'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [127:0] w;
    RST = 1'b1;
    bus.RX = 1'b1;
    bus.ACKNOWLEDGE = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_data", bus.DATA, 128'd0);
    check("rst_received", 128'(bus.RECEIVED), 128'd0);
    check("rst_error", 128'(bus.ERROR), 128'd0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    // 1: ramp word, hold without acknowledge, then release
    r0 = rises;
    send_bytes(128'h0F0E0D0C0B0A09080706050403020100, 16, BIT_NOM);
    @(negedge CLK);
    check("t1_received", 128'(bus.RECEIVED), 128'd1);
    check("t1_data", bus.DATA, 128'h0F0E0D0C0B0A09080706050403020100);
    repeat (120) @(negedge CLK);
    check("t1_hold", 128'(bus.RECEIVED), 128'd1);
    check("t1_data_hold", bus.DATA, 128'h0F0E0D0C0B0A09080706050403020100);
    ack_word("t1_ack");
    check("t1_rises", 128'(rises - r0), 128'd1);

    // 2: short low glitch, then a full 0xA5 word
    repeat (20) @(negedge CLK);
    bus.RX = 1'b0;
    #80;
    bus.RX = 1'b1;
    repeat (200) @(negedge CLK);
    check("t2_glitch_rcv", 128'(bus.RECEIVED), 128'd0);
    check("t2_glitch_err", 128'(bus.ERROR), 128'd0);
    send_bytes(fill(8'hA5), 15, BIT_NOM);
    @(negedge CLK);
    check("t2_no_count", 128'(bus.RECEIVED), 128'd0);
    send_byte(8'hA5, BIT_NOM, 1'b1);
    @(negedge CLK);
    check("t2_received", 128'(bus.RECEIVED), 128'd1);
    check("t2_data", bus.DATA, fill(8'hA5));
    ack_word("t2_ack");

    // 3: bad stop bit on byte 5
    repeat (20) @(negedge CLK);
    r0 = rises;
    w = ramp(8'h40);
    send_bytes(w, 5, BIT_NOM);
    send_byte(w[47:40], BIT_NOM, 1'b0);
    for (int k = 6; k < 16; k++) send_byte(w[8*k +: 8], BIT_NOM, 1'b1);
    @(negedge CLK);
    check("t3_error", 128'(bus.ERROR), 128'd1);
    check("t3_received", 128'(bus.RECEIVED), 128'd0);
    check("t3_no_rise", 128'(rises - r0), 128'd0);
    pulse_reset();
    check("t3_rst_error", 128'(bus.ERROR), 128'd0);
    check("t3_rst_data", bus.DATA, 128'd0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    send_bytes(ramp(8'hC0), 16, BIT_NOM);
    @(negedge CLK);
    check("t3_after_rcv", 128'(bus.RECEIVED), 128'd1);
    check("t3_after_data", bus.DATA, ramp(8'hC0));
    ack_word("t3_ack");

    // 4: partial word discarded by idle timeout
    repeat (20) @(negedge CLK);
    r0 = rises;
    send_bytes(fill(8'h77), 7, BIT_NOM);
    repeat (4000) @(negedge CLK);
    send_bytes(fill(8'h3C), 9, BIT_NOM);
    @(negedge CLK);
    check("t4_discarded", 128'(bus.RECEIVED), 128'd0);
    send_bytes(fill(8'h3C), 7, BIT_NOM);
    @(negedge CLK);
    check("t4_received", 128'(bus.RECEIVED), 128'd1);
    check("t4_data", bus.DATA, fill(8'h3C));
    check("t4_single", 128'(rises - r0), 128'd1);
    ack_word("t4_ack");

    // 5: bit period -3% and +3%
    repeat (20) @(negedge CLK);
    send_bytes(ramp(8'h5A), 16, BIT_FAST);
    @(negedge CLK);
    check("t5_fast_rcv", 128'(bus.RECEIVED), 128'd1);
    check("t5_fast_data", bus.DATA, ramp(8'h5A));
    ack_word("t5_fast_ack");
    repeat (20) @(negedge CLK);
    send_bytes(ramp(8'hA0), 16, BIT_SLOW);
    @(negedge CLK);
    check("t5_slow_rcv", 128'(bus.RECEIVED), 128'd1);
    check("t5_slow_data", bus.DATA, ramp(8'hA0));
    check("t5_slow_err", 128'(bus.ERROR), 128'd0);
    ack_word("t5_slow_ack");

    // 6: reset in the middle of byte 9
    repeat (20) @(negedge CLK);
    send_bytes(ramp(8'h10), 9, BIT_NOM);
    bus.RX = 1'b0;
    #(3 * BIT_NOM);
    pulse_reset();
    bus.RX = 1'b1;
    check("t6_rst_data", bus.DATA, 128'd0);
    check("t6_rst_rcv", 128'(bus.RECEIVED), 128'd0);
    check("t6_rst_err", 128'(bus.ERROR), 128'd0);
    RST = 1'b0;
    repeat (100) @(negedge CLK);
    send_bytes(ramp(8'hE0), 16, BIT_NOM);
    @(negedge CLK);
    check("t6_received", 128'(bus.RECEIVED), 128'd1);
    check("t6_data", bus.DATA, ramp(8'hE0));
    ack_word("t6_ack");

    // 7: acknowledge held high across DONE entry
    repeat (20) @(negedge CLK);
    r0 = rises;
    h0 = high_cycles;
    bus.ACKNOWLEDGE = 1'b1;
    send_bytes(fill(8'h96), 16, BIT_NOM);
    repeat (4) @(negedge CLK);
    check("t7_one_cycle", 128'(high_cycles - h0), 128'd1);
    check("t7_one_rise", 128'(rises - r0), 128'd1);
    check("t7_released", 128'(bus.RECEIVED), 128'd0);
    check("t7_data", bus.DATA, fill(8'h96));
    bus.ACKNOWLEDGE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
